// File: rtl/spike_packetizer.sv
// Spike packetizer: snapshots fired neurons at each step start, looks up each
// neuron's destination and streams one packet per neuron as LSB-first flits.
module spike_packetizer #(
  parameter int NUM_NEURONS          = 4,
  parameter int NEURON_CNT_BIT_WIDTH = 2,
  parameter int packet_size          = 32,
  parameter int flit_size            = 4,
  parameter int x_address_length     = 8,
  parameter int y_address_length     = 8,
  parameter int AXON_CNT_BIT_WIDTH   = 1
) (
  input  logic                                                            neuron_clk,
  input  logic                                                            rst_n,
  input  logic                                                            start,
  input  logic [NUM_NEURONS-1:0]                                          spike_in,
  input  logic                                                            cfg_we,
  input  logic [NEURON_CNT_BIT_WIDTH-1:0]                                 cfg_addr,
  input  logic [AXON_CNT_BIT_WIDTH+y_address_length+x_address_length:0]   cfg_data,
  input  logic                                                            router_full,
  output logic [flit_size-1:0]                                            data_out,
  output logic                                                            write_en,
  output logic                                                            busy,
  output logic                                                            done,
  output logic                                                            overrun
);

  localparam int FLITS  = packet_size / flit_size;
  localparam int CNT_W  = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int DEST_W = AXON_CNT_BIT_WIDTH + y_address_length + x_address_length;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state, state_nxt;
  logic [NUM_NEURONS-1:0]          pending, pending_nxt, clear_mask;
  logic [packet_size-1:0]          shift, shift_nxt;
  logic [CNT_W-1:0]                flit_cnt, flit_cnt_nxt;
  logic [DEST_W:0]                 dest_tbl [NUM_NEURONS];
  logic [NEURON_CNT_BIT_WIDTH-1:0] sel;
  logic                            last_accept;

  assign busy = (pending != '0) || (state != IDLE);

  // Lowest pending index wins, so neurons leave in ascending order.
  always_comb begin
    sel = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) sel = NEURON_CNT_BIT_WIDTH'(i);
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    flit_cnt_nxt = flit_cnt;
    clear_mask   = '0;
    last_accept  = 1'b0;
    write_en     = 1'b0;
    data_out     = '0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          clear_mask[sel] = 1'b1;
          // An invalid entry simply drops the neuron after one decision cycle.
          if (dest_tbl[sel][DEST_W]) begin
            shift_nxt               = '0;
            shift_nxt[DEST_W-1:0]   = dest_tbl[sel][DEST_W-1:0];
            flit_cnt_nxt            = '0;
            state_nxt               = SEND;
          end
        end
      end
      SEND: begin
        data_out = shift[flit_size-1:0];
        write_en = ~router_full;
        if (!router_full) begin
          shift_nxt    = shift >> flit_size;
          flit_cnt_nxt = flit_cnt + 1'b1;
          if (flit_cnt == CNT_W'(FLITS - 1)) begin
            last_accept = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending & ~clear_mask) | (start ? spike_in : '0);
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      shift    <= '0;
      flit_cnt <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      shift    <= shift_nxt;
      flit_cnt <= flit_cnt_nxt;
      done     <= last_accept && (pending == '0) && !start;
      overrun  <= start && busy;
    end
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) dest_tbl[i] <= '0;
    end else if (cfg_we) begin
      dest_tbl[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_spike_packetizer.sv
// Bench for spike_packetizer: table-driven scenarios, randomized trials against a
// transaction-level model, and a hand-written asynchronous reset sequence.
module tb_spike_packetizer;

  logic        neuron_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  spike_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic        router_full;
  logic [3:0]  data_out;
  logic        write_en, busy, done, overrun;

  spike_packetizer dut (
    .neuron_clk (neuron_clk),
    .rst_n      (rst_n),
    .start      (start),
    .spike_in   (spike_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .router_full(router_full),
    .data_out   (data_out),
    .write_en   (write_en),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 neuron_clk = ~neuron_clk;

  typedef struct {
    string       name;
    logic [3:0]  valid_mask;
    logic [3:0]  spike;
    int          full_at;
    int          full_len;
    int          start2_at;
    logic [3:0]  spike2;
    int          cfg_at;
    logic [1:0]  cfg_a;
    logic [17:0] cfg_w;
    int          exp_writes;
    int          exp_busy;
    int          exp_done;
    int          exp_overrun;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  obs_q[$];
  logic [3:0]  exp_q[$];
  logic [17:0] model_tbl[4];
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          ovr_cnt  = 0;
  int          total = 0;
  int          bad   = 0;

  // Passive monitor: every written flit and every output pulse, sampled mid-cycle.
  always @(negedge neuron_clk) begin
    if (write_en) obs_q.push_back(data_out);
    if (busy)    busy_cnt <= busy_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
    if (overrun) ovr_cnt  <= ovr_cnt + 1;
  end

  function automatic logic [16:0] baseDest(input int i);
    case (i)
      1:       baseDest = {1'b0, 8'h26, 8'h15};
      3:       baseDest = {1'b1, 8'h5C, 8'hA7};
      default: baseDest = {1'b1, 8'h02, 8'h03};
    endcase
  endfunction

  // Reference: fired neurons leave in ascending order, invalid ones vanish,
  // each packet is the zero-extended destination split into nibbles LSB first.
  task automatic buildExpected(input logic [3:0] fired);
    logic [31:0] pkt;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (fired[i] && model_tbl[i][17]) begin
        pkt = {15'b0, model_tbl[i][16:0]};
        for (int k = 0; k < 8; k++) exp_q.push_back(pkt[k*4 +: 4]);
      end
    end
  endtask

  task automatic checkOutput(input string nm, input int actual, input int required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", nm, actual, required);
    end
  endtask

  task automatic checkStream(input string nm, input int start_idx);
    int n;
    int mism;
    n = obs_q.size() - start_idx;
    mism = -1;
    checkOutput({nm, ".flit_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (mism < 0 && obs_q[start_idx + i] !== exp_q[i]) mism = i;
    end
    checkOutput({nm, ".first_bad_flit"}, mism, -1);
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [17:0] w);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = w;
    @(posedge neuron_clk); #1;
    cfg_we = 1'b0;
    model_tbl[a] = w;
  endtask

  task automatic tick();
    @(posedge neuron_clk); #1;
  endtask

  task automatic addVec(input string nm, input logic [3:0] vm, input logic [3:0] sp,
                        input int fa, input int fl, input int s2a, input logic [3:0] s2,
                        input int ca, input logic [1:0] cad, input logic [17:0] cw,
                        input int ew, input int eb, input int ed, input int eo);
    vec_t v;
    v.name = nm; v.valid_mask = vm; v.spike = sp; v.full_at = fa; v.full_len = fl;
    v.start2_at = s2a; v.spike2 = s2; v.cfg_at = ca; v.cfg_a = cad; v.cfg_w = cw;
    v.exp_writes = ew; v.exp_busy = eb; v.exp_done = ed; v.exp_overrun = eo;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    int         w0, b0, d0, o0;
    logic [3:0] held;
    bit         stalled, stall_ok;
    for (int i = 0; i < 4; i++) cfgWrite(2'(i), {v.valid_mask[i], baseDest(i)});
    w0 = obs_q.size(); b0 = busy_cnt; d0 = done_cnt; o0 = ovr_cnt;
    held = '0; stalled = 1'b0; stall_ok = 1'b1;
    start = 1'b1; spike_in = v.spike;
    tick();
    for (int k = 0; k < 45; k++) begin
      start       = (k == v.start2_at);
      spike_in    = start ? v.spike2 : 4'b0;
      router_full = (k >= v.full_at) && (k < v.full_at + v.full_len);
      cfg_we      = (k == v.cfg_at);
      cfg_addr    = v.cfg_a;
      cfg_data    = v.cfg_w;
      if (cfg_we) model_tbl[v.cfg_a] = v.cfg_w;
      @(negedge neuron_clk);
      if (router_full) begin
        if (!stalled) held = data_out;
        stalled = 1'b1;
        if (write_en || data_out !== held) stall_ok = 1'b0;
      end
      tick();
    end
    start = 1'b0; spike_in = '0; router_full = 1'b0; cfg_we = 1'b0;
    buildExpected(v.spike | ((v.start2_at >= 0) ? v.spike2 : 4'b0));
    checkOutput({v.name, ".writes"}, obs_q.size() - w0, v.exp_writes);
    checkStream(v.name, w0);
    checkOutput({v.name, ".busy_cycles"}, busy_cnt - b0, v.exp_busy);
    checkOutput({v.name, ".done_pulses"}, done_cnt - d0, v.exp_done);
    checkOutput({v.name, ".overrun_pulses"}, ovr_cnt - o0, v.exp_overrun);
    if (v.full_len > 0) checkOutput({v.name, ".stall_hold"}, int'(stall_ok), 1);
  endtask

  task automatic randomTrial();
    logic [3:0] sp;
    int         w0, d0, o0, hi, exp_done;
    bit         timed_out;
    for (int i = 0; i < 4; i++) cfgWrite(2'(i), 18'($urandom));
    sp = 4'($urandom_range(0, 15));
    w0 = obs_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    start = 1'b1; spike_in = sp;
    tick();
    start = 1'b0; spike_in = '0;
    timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      router_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    router_full = 1'b0;
    tick();
    tick();
    checkOutput("rand.finished", int'(timed_out), 0);
    buildExpected(sp);
    checkStream("rand", w0);
    hi = -1;
    for (int i = 0; i < 4; i++) if (sp[i]) hi = i;
    exp_done = (hi >= 0 && model_tbl[hi][17]) ? 1 : 0;
    checkOutput("rand.done_pulses", done_cnt - d0, exp_done);
    checkOutput("rand.overrun_pulses", ovr_cnt - o0, 0);
  endtask

  initial begin
    int w0, b0, d0, got;
    rst_n = 1'b0; start = 1'b0; spike_in = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; router_full = 1'b0;
    for (int i = 0; i < 4; i++) model_tbl[i] = '0;
    #12;
    checkOutput("reset.write_en", int'(write_en), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.data_out", int'(data_out), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.overrun", int'(overrun), 0);
    @(negedge neuron_clk);
    rst_n = 1'b1;
    tick();

    //     name            mask     spike    full   start2         cfg                          writes busy done ovr
    addVec("two_pkts",     4'b0101, 4'b0101, -1, 0, -1, 4'b0000, -1, 2'd0, 18'h0,                16, 18, 1, 0);
    addVec("backpressure", 4'b0101, 4'b0101,  4, 5, -1, 4'b0000, -1, 2'd0, 18'h0,                16, 23, 1, 0);
    addVec("invalid",      4'b0101, 4'b0010, -1, 0, -1, 4'b0000, -1, 2'd0, 18'h0,                 0,  1, 0, 0);
    addVec("overrun",      4'b1101, 4'b0101, -1, 0,  3, 4'b1000, -1, 2'd0, 18'h0,                24, 27, 1, 1);
    addVec("cfg_midsend",  4'b0101, 4'b0101, -1, 0, -1, 4'b0000,  3, 2'd2, {2'b10, 8'h9E, 8'h4D}, 16, 18, 1, 0);
    addVec("empty_start",  4'b1111, 4'b0000, -1, 0, -1, 4'b0000, -1, 2'd0, 18'h0,                 0,  0, 0, 0);
    addVec("all_four",     4'b1111, 4'b1111, -1, 0, -1, 4'b0000, -1, 2'd0, 18'h0,                32, 36, 1, 0);
    addVec("hi_invalid",   4'b0011, 4'b1001, -1, 0, -1, 4'b0000, -1, 2'd0, 18'h0,                 8, 10, 0, 0);
    addVec("merge",        4'b0101, 4'b0101, -1, 0,  3, 4'b0100, -1, 2'd0, 18'h0,                16, 18, 1, 1);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    for (int t = 0; t < 25; t++) randomTrial();

    // Asynchronous reset while flit 4 (value 1 from the axon bit) is on the bus.
    for (int i = 0; i < 4; i++) cfgWrite(2'(i), {1'b1, baseDest(i)});
    w0 = obs_q.size();
    start = 1'b1; spike_in = 4'b0101;
    tick();
    start = 1'b0; spike_in = '0;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      if (obs_q.size() - w0 >= 4) begin
        got = 1;
        break;
      end
      tick();
    end
    checkOutput("rst.reached_flit4", got, 1);
    checkOutput("rst.write_en_before", int'(write_en), 1);
    checkOutput("rst.data_out_before", int'(data_out), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.write_en_async", int'(write_en), 0);
    checkOutput("rst.busy_async", int'(busy), 0);
    checkOutput("rst.data_out_async", int'(data_out), 0);
    @(negedge neuron_clk);
    rst_n = 1'b1;
    tick();
    w0 = obs_q.size(); b0 = busy_cnt; d0 = done_cnt;
    for (int k = 0; k < 15; k++) tick();
    checkOutput("rst.flits_after_release", obs_q.size() - w0, 0);
    checkOutput("rst.busy_after_release", busy_cnt - b0, 0);

    // Table valid bits were cleared by reset, so a new start sends nothing.
    for (int i = 0; i < 4; i++) model_tbl[i][17] = 1'b0;
    start = 1'b1; spike_in = 4'b0101;
    tick();
    start = 1'b0; spike_in = '0;
    for (int k = 0; k < 15; k++) tick();
    checkOutput("rst.table_cleared_flits", obs_q.size() - w0, 0);
    checkOutput("rst.table_cleared_done", done_cnt - d0, 0);

    cfgWrite(2'd0, {1'b1, baseDest(3)});
    w0 = obs_q.size(); d0 = done_cnt;
    start = 1'b1; spike_in = 4'b0001;
    tick();
    start = 1'b0; spike_in = '0;
    for (int k = 0; k < 14; k++) tick();
    buildExpected(4'b0001);
    checkStream("rst.recover", w0);
    checkOutput("rst.recover_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_packetizer.md
Name: spike_packetizer

Overview:
- Transmit-side counterpart of the neuron-core spike receiver. Runs in the neuron clock domain.
- At each step `start`, snapshots the neuron fire vector and looks up each fired neuron's destination (x, y, axon) in a small config-written table.
- Builds one `packet_size` packet per fired neuron and serializes it into `flit_size` flits toward the router injection FIFO, using write_en/full flow control.

Parameters:
- NUM_NEURONS, 4, number of neurons (fire-vector width).
- NEURON_CNT_BIT_WIDTH, 2, index width, clog2(NUM_NEURONS).
- packet_size, 32, packet width in bits.
- flit_size, 4, flit width; packet_size must be a multiple of flit_size; FLITS = packet_size/flit_size (8).
- x_address_length, 8, destination X field width.
- y_address_length, 8, destination Y field width.
- AXON_CNT_BIT_WIDTH, 1, destination axon-id field width.

Ports:
- neuron_clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  step pulse; fire vector sampled on the edge where start=1.
- spike_in  in  NUM_NEURONS  fired-neuron bitmap, bit i = neuron i.
- cfg_we  in  1  destination-table write enable.
- cfg_addr  in  NEURON_CNT_BIT_WIDTH  table index.
- cfg_data  in  1+AXON+Y+X bits  {valid, axon_id, y, x}.
- router_full  in  1  downstream FIFO full; a flit is not accepted while high.
- data_out  out  flit_size  current flit.
- write_en  out  1  flit write strobe; one flit transferred per cycle it is high.
- busy  out  1  pending bitmap nonzero or state != IDLE.
- done  out  1  one-cycle pulse when the last pending packet's final flit is accepted.
- overrun  out  1  one-cycle pulse when start is sampled while busy.

Behaviour:
- Reset (async): state=IDLE, pending=0, flit_cnt=0, shift reg=0, table valid bits=0.
  - data_out=0, write_en=0, busy=0, done=0, overrun=0.
  - write_en drops immediately on rst_n low, including mid-packet; the partial packet is abandoned.
- Table: written on edge with cfg_we=1. Writes are legal at any time. An entry is read only when its neuron is selected for packetization.
- Start sampling: on edge with start=1, pending <= pending | spike_in.
  - If busy was 1 on that edge, overrun pulses the next cycle.
  - Bits already pending are merged, never duplicated.
- Packet format: packet[X-1:0]=x, [X+Y-1:X]=y, [X+Y+A-1:X+Y]=axon_id, upper bits 0. Flits go out LSB first: flit k = packet[k*flit_size +: flit_size].
- FSM:
  - IDLE: if pending!=0, select the lowest set index i and clear pending[i] on this edge (the same-edge start OR still applies to the other bits).
    - If table[i].valid: load shift reg with the packet, flit_cnt=0, go to SEND.
    - Else: stay in IDLE; neuron i is dropped at 1 cycle cost.
  - SEND: data_out = shift[flit_size-1:0]; write_en = ~router_full (combinational from state and router_full).
    - On each accept: shift right by flit_size, flit_cnt+1.
    - On the accept with flit_cnt==FLITS-1: go to IDLE. done pulses next cycle if pending==0 and no start arrives on that edge.
  - router_full high holds data_out stable, with flit_cnt unchanged, indefinitely.
- Timing: start sampled at edge E0 → SEND entered at E1 → flit 0 written in the cycle after E1. With no backpressure, each packet takes 9 cycles (1 IDLE + 8 SEND).
- An empty start (spike_in=0, nothing pending) produces no packets and no done pulse.
- Count widths: flit_cnt is clog2(FLITS) bits and wraps only via reset to 0 at packet load.

Test Plan:
1. Table entries 0 and 2 = {1, axon 1, y=0x02, x=0x03}, start with spike_in=4'b0101 → two packets 0x0001_0203, each sent as 8 flits 3,0,2,0,1,0,0,0. 16 write_en cycles over 18 cycles; done pulses once; busy covers the whole window.
2. Same as scenario 1, but router_full held high for 5 cycles during flit 3 → write_en low for those 5 cycles, data_out holds 0; sequence resumes intact; total 23 cycles.
3. Entry 1 invalid, spike_in=4'b0010 → no write_en, busy high 1 cycle, done not pulsed (per the done rule, check bench expects none).
4. Second start with spike_in=4'b1000 during packet 0 of scenario 1 → overrun pulses once; neuron 3 is sent after neuron 2 (3 packets total); done pulses once at the end.
5. rst_n low mid-packet (after flit 4) → write_en, busy, data_out go to 0 asynchronously; after release no flits are sent until a new start.
6. Config write to entry 2 while neuron 0's packet is in SEND → neuron 2's packet uses the new x/y/axon.
